butterfly_ct: RTL and testbench

Cooley-Tukey (decimation-in-time) radix-2 butterfly over the Goldilocks field p = 2^64 - 2^32 + 1: t = y*w mod p, x_o = x + t mod p, y_o = x - t mod p. It is the inverse-direction counterpart of the Gentleman-Sande butterfly (x+y, (x-y)*w), used in the INTT datapath so that an INTT stage undoes the matching NTT stage. Unlike the ce-driven forward butterfly, it has a valid/ready stream interface with internal stall handling and a sideband tag, so it can sit directly between INTT stage FIFOs.

---
 rtl/butterfly_ct_if.sv | 32 +++
 rtl/butterfly_ct.sv | 125 ++++++++++++
 tb/tb_butterfly_ct.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_ct_if.sv
// Stream interface of the Cooley-Tukey butterfly: operand/tag input side,
// result/tag output side and the busy status.
`timescale 1ns/1ps
interface butterfly_ct_if #(
   parameter int unsigned TAG_W = 8
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic             nop_i;
   logic [63:0]      x_i;
   logic [63:0]      y_i;
   logic [63:0]      w_i;
   logic [TAG_W-1:0] tag_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [63:0]      x_o;
   logic [63:0]      y_o;
   logic [TAG_W-1:0] tag_o;
   logic             busy_o;

   // Butterfly side
   modport slave (
      input  in_valid_i, nop_i, x_i, y_i, w_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, x_o, y_o, tag_o, busy_o
   );

   // Producer/consumer side
   modport master (
      output in_valid_i, nop_i, x_i, y_i, w_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, x_o, y_o, tag_o, busy_o
   );
endinterface

// File: rtl/butterfly_ct.sv
// Radix-2 DIT butterfly over Goldilocks p = 2^64 - 2^32 + 1:
// t = y*w mod p, x_o = x + t, y_o = x - t. Valid/ready pipeline with one
// global advance; bubbles stay in the pipe. Payload registers are not reset.
`timescale 1ns/1ps
module butterfly_ct #(
   parameter int unsigned MUL_STAGES = 4,
   parameter bit          CANONICAL  = 1'b1,
   parameter int unsigned TAG_W      = 8
) (
   input logic           clk_i,
   input logic           rst_ni,
   butterfly_ct_if.slave bus
);
   localparam int unsigned LAT = MUL_STAGES + 2;
   localparam int unsigned RED = MUL_STAGES;        // reduce stage index
   localparam logic [63:0] P   = 64'hFFFF_FFFF_0000_0001;

   logic [LAT-1:0]   v;
   logic             adv;
   logic             accept;

   logic [TAG_W-1:0] tag_q  [LAT];
   logic [63:0]      x_q    [LAT-1];
   logic [63:0]      y_q    [LAT-1];
   logic             nop_q  [LAT-1];
   logic [127:0]     prod_q [MUL_STAGES];
   logic [63:0]      t_q;
   logic [63:0]      xo_q;
   logic [63:0]      yo_q;

   logic [63:0]      w_eff;
   logic [127:0]     prod_in;
   logic [65:0]      r;
   logic [63:0]      t_red;
   logic [63:0]      x_red;
   logic [64:0]      s_full;
   logic [64:0]      d_full;
   logic [63:0]      sum;
   logic [63:0]      dif;

   // Handshake: whole pipe moves unless a result is waiting unconsumed
   assign adv             = !v[LAT-1] || bus.out_ready_i;
   assign accept          = bus.in_valid_i && adv;
   assign bus.in_ready_o  = adv;
   assign bus.out_valid_o = v[LAT-1];
   assign bus.x_o         = xo_q;
   assign bus.y_o         = yo_q;
   assign bus.tag_o       = tag_q[LAT-1];
   assign bus.busy_o      = |v;

   // Product of the incoming operands; nop forces w = 1
   always_comb begin
      w_eff   = bus.nop_i ? 64'd1 : bus.w_i;
      prod_in = 128'(bus.y_i) * 128'(w_eff);
   end

   // Goldilocks reduction of the 128-bit product using 2^64 = 2^32 - 1, 2^96 = -1
   always_comb begin
      r     = 66'(prod_q[MUL_STAGES-1][63:0])
            - 66'(prod_q[MUL_STAGES-1][127:96])
            + 66'({prod_q[MUL_STAGES-1][95:64], 32'h0})
            - 66'(prod_q[MUL_STAGES-1][95:64]);
      if (r[65]) begin
         r = r + 66'(P);
      end else if (r[64]) begin
         r = r - 66'(P);
      end
      t_red = r[63:0];
      if (CANONICAL && (t_red >= P)) begin
         t_red = t_red - P;
      end
   end

   // Modular add/sub of x and t
   always_comb begin
      x_red = x_q[RED];
      if (CANONICAL && (x_red >= P)) begin
         x_red = x_red - P;
      end
      s_full = 65'(x_red) + 65'(t_q);
      sum    = s_full[63:0];
      if (s_full[64] || (CANONICAL && (s_full[63:0] >= P))) begin
         sum = s_full[63:0] - P;
      end
      d_full = 65'(x_red) - 65'(t_q);
      dif    = d_full[63:0];
      if (d_full[64]) begin
         dif = d_full[63:0] + P;
      end
   end

   // Valid bits: the only reset state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v <= '0;
      end else if (adv) begin
         v <= {v[LAT-2:0], accept};
      end
   end

   // Payload shift on advance
   always_ff @(posedge clk_i) begin
      if (adv) begin
         tag_q[0]  <= bus.tag_i;
         x_q[0]    <= bus.x_i;
         y_q[0]    <= bus.y_i;
         nop_q[0]  <= bus.nop_i;
         prod_q[0] <= prod_in;
         for (int k = 1; k < LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
         for (int k = 1; k < LAT - 1; k++) begin
            x_q[k]   <= x_q[k-1];
            y_q[k]   <= y_q[k-1];
            nop_q[k] <= nop_q[k-1];
         end
         for (int k = 1; k < MUL_STAGES; k++) begin
            prod_q[k] <= prod_q[k-1];
         end
         t_q  <= t_red;
         xo_q <= nop_q[RED] ? x_q[RED] : sum;
         yo_q <= nop_q[RED] ? y_q[RED] : dif;
      end
   end
endmodule

// File: tb/tb_butterfly_ct.sv
// Scoreboard bench for butterfly_ct: driver pushes expected results on accept,
// monitor pops and compares on each output handshake and checks stall stability.
`timescale 1ns/1ps
module tb_butterfly_ct;
   localparam int unsigned MUL_STAGES = 4;
   localparam int unsigned LAT        = MUL_STAGES + 2;
   localparam logic [63:0] PM         = 64'hFFFF_FFFF_0000_0001;

   typedef struct {
      logic [63:0] x;
      logic [63:0] y;
      logic [7:0]  tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   bit   rand_ready;
   exp_t sb[$];

   butterfly_ct_if #(.TAG_W(8)) bus ();

   butterfly_ct #(
      .MUL_STAGES(MUL_STAGES),
      .CANONICAL (1'b1),
      .TAG_W     (8)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                  input logic [63:0] w, input logic nop, input logic [7:0] tg);
      exp_t         e;
      logic [127:0] prod;
      logic [63:0]  t;
      logic [63:0]  xr;
      logic [64:0]  s;
      e.tag = tg;
      e.x   = x;
      e.y   = y;
      if (!nop) begin
         prod = {64'b0, y} * {64'b0, w};
         t    = 64'(prod % {64'b0, PM});
         xr   = x % PM;
         s    = ({1'b0, xr} + {1'b0, t}) % {1'b0, PM};
         e.x  = s[63:0];
         s    = ({1'b0, xr} + {1'b0, PM} - {1'b0, t}) % {1'b0, PM};
         e.y  = s[63:0];
      end
      return e;
   endfunction

   // Called right after a falling edge; returns on the falling edge after acceptance
   task automatic send(input logic [63:0] x, input logic [63:0] y, input logic [63:0] w,
                       input logic nop, input logic [7:0] tg, input exp_t e);
      int tries;
      tries          = 0;
      bus.in_valid_i = 1'b1;
      bus.x_i        = x;
      bus.y_i        = y;
      bus.w_i        = w;
      bus.nop_i      = nop;
      bus.tag_i      = tg;
      forever begin
         #1;
         if (bus.in_ready_o) begin
            sb.push_back(e);
            @(negedge clk);
            break;
         end
         tries++;
         if (tries > 1000) begin
            check("accept_timeout", 64'(bus.in_ready_o), 64'd1);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue", 64'(sb.size()), 64'd0);
   endtask

   // Cycles from driving an item to seeing out_valid must be LAT
   task automatic latency(input logic [7:0] tg);
      int cnt;
      send(64'd5, 64'd3, 64'd2, 1'b0, tg, '{x: 64'hB, y: 64'hFFFF_FFFF_0000_0000, tag: tg});
      cnt = 1;
      #2;
      while (!bus.out_valid_o && cnt < 50) begin
         @(negedge clk);
         #2;
         cnt++;
      end
      check("latency", 64'(cnt), 64'(LAT));
   endtask

   // Consumer readiness
   initial begin
      bus.out_ready_i = 1'b1;
      forever begin
         @(negedge clk);
         bus.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: compare on handshake, check outputs frozen while stalled
   initial begin
      bit          held;
      logic [63:0] hx;
      logic [63:0] hy;
      logic [7:0]  ht;
      exp_t        e;
      held = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_x", bus.x_o, hx);
               check("stall_y", bus.y_o, hy);
               check("stall_tag_valid", 64'({bus.out_valid_o, bus.tag_o}), 64'({1'b1, ht}));
            end
            if (bus.out_valid_o) begin
               if (bus.out_ready_i) begin
                  held = 1'b0;
                  if (sb.size() == 0) begin
                     check("unexpected_output", 64'(bus.tag_o), 64'hFFFF);
                  end else begin
                     e = sb.pop_front();
                     check("x_o", bus.x_o, e.x);
                     check("y_o", bus.y_o, e.y);
                     check("tag_o", 64'(bus.tag_o), 64'(e.tag));
                  end
               end else begin
                  held = 1'b1;
                  hx   = bus.x_o;
                  hy   = bus.y_o;
                  ht   = bus.tag_o;
               end
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Main stimulus
   initial begin
      logic [63:0] rx;
      logic [63:0] ry;
      logic [63:0] rw;
      logic        rn;
      total          = 0;
      bad            = 0;
      rand_ready     = 1'b0;
      rst_n          = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.nop_i      = 1'b0;
      bus.x_i        = '0;
      bus.y_i        = '0;
      bus.w_i        = '0;
      bus.tag_i      = '0;
      #2;
      check("reset_out_valid", 64'(bus.out_valid_o), 64'd0);
      check("reset_busy", 64'(bus.busy_o), 64'd0);
      check("reset_in_ready", 64'(bus.in_ready_o), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, back to back
      send(64'd5, 64'd3, 64'd2, 1'b0, 8'h11,
           '{x: 64'hB, y: 64'hFFFF_FFFF_0000_0000, tag: 8'h11});
      send(64'd0, 64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 8'h12,
           '{x: 64'hFFFF_FFFF_0000_0000, y: 64'h1, tag: 8'h12});
      send(64'hFFFF_FFFF_0000_0001, 64'd0, 64'h1234, 1'b0, 8'h13,
           '{x: 64'h0, y: 64'h0, tag: 8'h13});
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd0, 1'b1, 8'h14,
           '{x: 64'hFFFF_FFFF_FFFF_FFFF, y: 64'h7, tag: 8'h14});
      drain();

      latency(8'h20);
      drain();

      // Random operands, random valid gaps and consumer stalls
      rand_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         rw = {$urandom, $urandom};
         if (i % 17 == 3) rx = PM + 64'($urandom_range(0, 5));
         if (i % 13 == 5) ry = 64'hFFFF_FFFF_FFFF_FFFF;
         rn = ($urandom_range(0, 7) == 0);
         send(rx, ry, rw, rn, 8'(i), model(rx, ry, rw, rn, 8'(i)));
      end
      drain();
      rand_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Asynchronous reset with items in flight
      for (int i = 0; i < 3; i++) begin
         send(64'd1, 64'd1, 64'd1, 1'b0, 8'(8'hA0 + i), '{x: 64'h2, y: 64'h0, tag: 8'(8'hA0 + i)});
      end
      #3;
      check("busy_before_reset", 64'(bus.busy_o), 64'd1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("async_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      check("async_rst_busy", 64'(bus.busy_o), 64'd0);
      check("async_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);
      latency(8'h33);
      drain();
      repeat (LAT + 2) @(negedge clk);
      check("final_busy", 64'(bus.busy_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
